// File: rtl/uart_burst_tx.sv
// Buffered UART transmitter: bytes are queued in a small FIFO, a send pulse
// drains the whole queue back-to-back on txd, then the line is held idle for
// GAP_CYCLES clocks before a one-clock burst_done pulse.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit per frame.
module uart_burst_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          send,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          txd,
  output logic                          burst_done
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int LW       = PW + 1;

  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_GAP
  } state_t;

  state_t          state_q;
  logic            txd_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [GW-1:0]   gap_q;
  logic [7:0]      sh_q;
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;
  logic            full_q;
  logic            push;
  logic            pop;

  // A write is judged against the registered full flag, so a pop in the same
  // cycle cannot rescue a write issued while full.
  assign push = wr_en && !full_q;
  assign pop  = (state_q == S_LOAD);

  // Next occupancy from this cycle's push/pop.
  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // FIFO pointers, occupancy and registered full flag; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Transmit FSM; txd, busy and burst_done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (send && (level_q != '0)) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          sh_q    <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          par_q   <= ^mem_q[rd_ptr_q];
`endif
          state_q <= S_START;
          txd_q   <= 1'b0;
          baud_q  <= BAUD_LOAD;
        end
        S_START: begin
          if (baud_q == '0) begin
            state_q <= S_DATA;
            txd_q   <= sh_q[0];
            bit_q   <= '0;
            baud_q  <= BAUD_LOAD;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LOAD;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= {1'b0, sh_q[7:1]};
              txd_q <= sh_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_q == '0) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
            baud_q  <= BAUD_LOAD;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          txd_q <= 1'b1;
          if (baud_q == '0) begin
            if (level_q != '0) begin
              // Next byte follows; the LOAD cycle stretches this stop bit by one.
              state_q <= S_LOAD;
            end else if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_GAP;
              gap_q   <= GAP_LOAD;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_GAP: begin
          txd_q <= 1'b1;
          if (gap_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full       = full_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign txd        = txd_q;
  assign burst_done = done_q;

endmodule
